temp_alarm_ctrl: RTL
====================

Name: temp_alarm_ctrl

Overview:
Alarm classifier directly upstream of the buzzer driver. It takes 8-bit temperature samples from the sensor interface and applies hysteresis thresholds plus a persistence filter. It drives the buzzer's 2-bit `acionar` command (01 = hot, 10 = cold, 00 = silent) and supports an operator mute with automatic timeout.

Parameters:
- HOT_ON, 40: hot alarm entry threshold, degrees C, unsigned; a sample >= HOT_ON counts as hot.
- HOT_OFF, 37: hot alarm exit threshold; a sample <= HOT_OFF leaves HOT.
- COLD_ON, 10: cold alarm entry threshold; a sample <= COLD_ON counts as cold.
- COLD_OFF, 13: cold alarm exit threshold; a sample >= COLD_OFF leaves COLD.
- PERSIST, 4: consecutive qualifying valid samples needed to enter an alarm (1..15).
- MUTE_CYCLES, 500_000_000: mute duration in clk cycles (10 s at 50 MHz); 32-bit timer.
- Legal set: COLD_ON < COLD_OFF < HOT_OFF < HOT_ON. Other settings are unsupported, and the bench uses legal values only.

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  asynchronous active-high reset
- temp_valid  in  1  one-cycle strobe; temp_data is sampled only when high
- temp_data  in  8  unsigned temperature, degrees C
- ack  in  1  operator mute request, level; rising edge detected internally
- acionar  out  2  buzzer command: 01 hot, 10 cold, 00 off
- alarm_active  out  1  high in HOT or COLD, regardless of mute
- muted  out  1  mute currently in effect

Behaviour:
- Reset is asynchronous and active-high (rst). On reset: state = NORMAL, persistence count = 0, mute timer = 0, muted = 0, acionar = 00, alarm_active = 0, ack edge register = 0. Asserting reset mid-alarm clears everything immediately, without waiting for a clock edge.
- FSM states: NORMAL, HOT_PEND, HOT, COLD_PEND, COLD. The FSM advances only on cycles where temp_valid = 1; otherwise it holds.
- NORMAL:
  - sample >= HOT_ON: go to HOT_PEND with cnt = 1. If PERSIST = 1, go directly to HOT instead.
  - sample <= COLD_ON: same behaviour toward COLD_PEND / COLD.
  - otherwise: stay in NORMAL.
- HOT_PEND:
  - sample >= HOT_ON: cnt increments; when cnt + 1 == PERSIST, go to HOT and clear cnt.
  - any other sample: go to NORMAL with cnt = 0. A cold sample is not re-evaluated in that same cycle.
- COLD_PEND: mirror of HOT_PEND using sample <= COLD_ON.
- HOT: stay while sample > HOT_OFF; sample <= HOT_OFF goes to NORMAL immediately (no persistence).
- COLD: stay while sample < COLD_OFF; sample >= COLD_OFF goes to NORMAL immediately.
- Samples between the OFF and ON thresholds leave HOT/COLD unchanged. That band is the hysteresis.
- Output decode:
  - alarm_active = (state == HOT) or (state == COLD).
  - acionar = 01 when HOT and not muted; 10 when COLD and not muted; 00 otherwise.
  - Outputs are decoded from registered state and mute only, so they are glitch-free. They change on the same edge as the state register.
- Mute:
  - A rising edge of ack (ack = 1, previous ack = 0) while in HOT or COLD sets muted = 1 and loads the timer with MUTE_CYCLES - 1.
  - A rising edge of ack while already muted reloads the timer.
  - A rising edge of ack in NORMAL or PEND states is ignored.
  - While muted, the timer decrements every clk. muted clears on the edge where the timer is 0.
- Mute clears on the same edge that the state leaves HOT or COLD. A new alarm is therefore never pre-muted.
- Simultaneous events:
  - ack edge on the same cycle as an exit sample: the exit wins, giving muted = 0.
  - ack edge on the same cycle the state enters HOT: ignored, because the state is not yet HOT.
- Latency: the valid sample completing persistence produces acionar on the next clk edge, i.e. 1 cycle after the temp_valid cycle.

Optional Feature:
- Macro: TEMP_ALARM_PEAK_EN.
- When defined, the block adds output ports peak_temp[7:0] and peak_clr (input, 1).
  - peak_temp holds the maximum sample seen in HOT or the minimum sample seen in COLD during the current alarm episode.
  - It is loaded with the entering sample on the transition into HOT or COLD, and updated on each valid sample inside the alarm.
  - It holds its value after returning to NORMAL, so the extreme can be shown on the display.
  - peak_clr = 1 or reset sets it to 0.
- When not defined, these ports and registers do not exist and all other behaviour is identical.

Test Plan:
- Bench overrides MUTE_CYCLES = 100; all other parameters at defaults.
- Reset then samples 25,25 -> acionar = 00, alarm_active = 0, state NORMAL.
- Valid samples 41,42,40,45 -> acionar = 01 one cycle after the 4th strobe. Then 38 -> stays 01; then 37 -> acionar = 00.
- Samples 41,42,39,41 -> no alarm (persistence broken at 39). Then 41,41,41,41 -> acionar = 01.
- Samples 9,10,5,8 -> acionar = 10. Then 12 -> stays 10; then 13 -> 00.
- In HOT, pulse ack -> acionar = 00, muted = 1, alarm_active = 1. After 100 clks -> acionar = 01. Re-ack at cycle 50 extends the mute to 150.
- In HOT with muted = 1, assert rst for 1 cycle mid-period -> all outputs 0 immediately. Then sample 45 -> enters HOT_PEND, not HOT.

Source files
------------

// File: rtl/temp_alarm_if.sv
// temp_alarm_if: sample, ack and buzzer-command bundle for temp_alarm_ctrl.
//   master : sensor/operator side (drives temp_valid, temp_data, ack)
//   slave  : temp_alarm_ctrl (drives acionar, alarm_active, muted)
// Optional TEMP_ALARM_PEAK_EN adds peak_clr (master->slave) and
// peak_temp (slave->master).
interface temp_alarm_if;
    logic       temp_valid;
    logic [7:0] temp_data;
    logic       ack;
    logic [1:0] acionar;
    logic       alarm_active;
    logic       muted;
`ifdef TEMP_ALARM_PEAK_EN
    logic [7:0] peak_temp;
    logic       peak_clr;

    modport master (
        output temp_valid, temp_data, ack, peak_clr,
        input  acionar, alarm_active, muted, peak_temp
    );
    modport slave (
        input  temp_valid, temp_data, ack, peak_clr,
        output acionar, alarm_active, muted, peak_temp
    );
`else
    modport master (
        output temp_valid, temp_data, ack,
        input  acionar, alarm_active, muted
    );
    modport slave (
        input  temp_valid, temp_data, ack,
        output acionar, alarm_active, muted
    );
`endif
endinterface

// File: rtl/temp_alarm_ctrl.sv
// temp_alarm_ctrl: hysteresis + persistence temperature alarm classifier
// feeding the buzzer driver, with operator mute and mute timeout.
// Ports:
//   clk    : system clock
//   rst    : asynchronous active-high reset
//   if_bus : temp_alarm_if.slave
//            in : temp_valid, temp_data[7:0], ack (level, edge-detected)
//            out: acionar[1:0] (01 hot, 10 cold, 00 off), alarm_active, muted
// Optional feature macro TEMP_ALARM_PEAK_EN: adds peak_clr in / peak_temp out,
// the per-episode extreme sample (max in HOT, min in COLD).
module temp_alarm_ctrl #(
    parameter logic [7:0]  HOT_ON      = 8'd40,
    parameter logic [7:0]  HOT_OFF     = 8'd37,
    parameter logic [7:0]  COLD_ON     = 8'd10,
    parameter logic [7:0]  COLD_OFF    = 8'd13,
    parameter int unsigned PERSIST     = 4,
    parameter logic [31:0] MUTE_CYCLES = 32'd500_000_000
) (
    input  logic         clk,
    input  logic         rst,
    temp_alarm_if.slave  if_bus
);

    typedef enum logic [2:0] {
        S_NORMAL,
        S_HOT_PEND,
        S_HOT,
        S_COLD_PEND,
        S_COLD
    } state_t;

    localparam logic [3:0] PERSIST_C = 4'(PERSIST);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_mute_tmr;
    logic        r_muted;
    logic        r_ack_d;

    logic        w_hot_smp, w_cold_smp;
    logic        w_in_alarm, w_leave, w_ack_rise;

    assign w_hot_smp  = (if_bus.temp_data >= HOT_ON);
    assign w_cold_smp = (if_bus.temp_data <= COLD_ON);
    assign w_in_alarm = (r_state == S_HOT) || (r_state == S_COLD);
    assign w_leave    = w_in_alarm && (w_state_nxt == S_NORMAL);
    assign w_ack_rise = if_bus.ack && !r_ack_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_NORMAL;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state only moves on a valid sample. A pending run broken by any
    // non-qualifying sample drops to NORMAL; the breaking sample is not
    // re-classified, so a cold sample in HOT_PEND does not start COLD_PEND.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (if_bus.temp_valid) begin
            case (r_state)
                S_NORMAL: begin
                    if (w_hot_smp) begin
                        if (PERSIST_C == 4'd1) begin
                            w_state_nxt = S_HOT;
                        end else begin
                            w_state_nxt = S_HOT_PEND;
                            w_cnt_nxt   = 4'd1;
                        end
                    end else if (w_cold_smp) begin
                        if (PERSIST_C == 4'd1) begin
                            w_state_nxt = S_COLD;
                        end else begin
                            w_state_nxt = S_COLD_PEND;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_HOT_PEND: begin
                    if (w_hot_smp) begin
                        if (r_cnt + 4'd1 == PERSIST_C) begin
                            w_state_nxt = S_HOT;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = S_NORMAL;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_COLD_PEND: begin
                    if (w_cold_smp) begin
                        if (r_cnt + 4'd1 == PERSIST_C) begin
                            w_state_nxt = S_COLD;
                            w_cnt_nxt   = 4'd0;
                        end else begin
                            w_cnt_nxt   = r_cnt + 4'd1;
                        end
                    end else begin
                        w_state_nxt = S_NORMAL;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                S_HOT: begin
                    if (if_bus.temp_data <= HOT_OFF) w_state_nxt = S_NORMAL;
                end
                S_COLD: begin
                    if (if_bus.temp_data >= COLD_OFF) w_state_nxt = S_NORMAL;
                end
                default: begin
                    w_state_nxt = S_NORMAL;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    // Mute: leaving the alarm has priority over an ack edge, so an episode
    // never ends muted and the next one always starts audible. The ack edge
    // is judged against the registered state, so an ack on the entry cycle
    // is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_d    <= 1'b0;
            r_muted    <= 1'b0;
            r_mute_tmr <= 32'd0;
        end else begin
            r_ack_d <= if_bus.ack;
            if (w_leave) begin
                r_muted    <= 1'b0;
                r_mute_tmr <= 32'd0;
            end else if (w_ack_rise && w_in_alarm) begin
                r_muted    <= 1'b1;
                r_mute_tmr <= MUTE_CYCLES - 32'd1;
            end else if (r_muted) begin
                if (r_mute_tmr == 32'd0) r_muted    <= 1'b0;
                else                     r_mute_tmr <= r_mute_tmr - 32'd1;
            end
        end
    end

    // Decoded purely from registers: no path from inputs to outputs.
    assign if_bus.alarm_active = w_in_alarm;
    assign if_bus.muted        = r_muted;
    assign if_bus.acionar      = r_muted              ? 2'b00 :
                                 (r_state == S_HOT)  ? 2'b01 :
                                 (r_state == S_COLD) ? 2'b10 : 2'b00;

`ifdef TEMP_ALARM_PEAK_EN
    logic [7:0] r_peak;

    // Loaded with the entering sample, tracked while in the alarm, and held
    // after the episode ends so the display can still show it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_peak <= 8'd0;
        end else if (if_bus.peak_clr) begin
            r_peak <= 8'd0;
        end else if (if_bus.temp_valid) begin
            if ((w_state_nxt == S_HOT) && (r_state != S_HOT))
                r_peak <= if_bus.temp_data;
            else if ((w_state_nxt == S_COLD) && (r_state != S_COLD))
                r_peak <= if_bus.temp_data;
            else if ((r_state == S_HOT) && (if_bus.temp_data > r_peak))
                r_peak <= if_bus.temp_data;
            else if ((r_state == S_COLD) && (if_bus.temp_data < r_peak))
                r_peak <= if_bus.temp_data;
        end
    end

    assign if_bus.peak_temp = r_peak;
`endif

endmodule
